// File: rtl/usb_ep_pkg.sv
// -----------------------------------------------------------------------------
// usb_ep_pkg
// Shared definitions for the USB IN endpoint buffer:
//   - ep_state_e           : endpoint buffer FSM states
//   - DEFAULT_MAX_PKT_SIZE : default packet buffer depth (bMaxPacketSize0)
// -----------------------------------------------------------------------------
package usb_ep_pkg;

    localparam int DEFAULT_MAX_PKT_SIZE = 32;

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,  // endpoint writes bytes, IN tokens get NAK
        ST_READY    = 2'd1,  // packet committed, waiting for an IN token
        ST_SENDING  = 2'd2,  // engine is popping bytes
        ST_WAIT_ACK = 2'd3   // packet sent, waiting for the host handshake
    } ep_state_e;

endpackage

// File: rtl/usb_ep_pkt_ram.sv
// -----------------------------------------------------------------------------
// usb_ep_pkt_ram
// Packet storage: DEPTH x 8 bit memory, one synchronous write port and one
// asynchronous read port so the transmit byte falls through without latency.
// Ports:
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
// -----------------------------------------------------------------------------
module usb_ep_pkt_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    // Sized to the full address space so any raddr_i value stays in range.
    logic [7:0] mem_q [2**AW];

    // NOTE: the storage array has no reset; its contents are only meaningful
    // below the committed byte count, which is what gets cleared on reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_ctrl_in_ep_buf.sv
// -----------------------------------------------------------------------------
// usb_ctrl_in_ep_buf
// Single-packet IN endpoint buffer between a control endpoint and the USB
// full-speed transmit engine. Collects bytes into one packet, answers IN
// tokens with DATA/NAK/STALL, tracks the DATA0/DATA1 toggle, retransmits on
// handshake timeout and reports host ACK to the endpoint.
// Ports:
//   clk, reset (sync, active-high)
//   in_ep_req/grant, in_ep_data_free/put/data/data_done, in_ep_stall,
//   in_ep_acked                        : endpoint side
//   setup_token                        : SETUP seen on this endpoint
//   tx_in_token, tx_data_avail/get/data, tx_pid_data1, tx_rsp_nak,
//   tx_rsp_stall, rx_ack, tx_timeout   : protocol engine side
// -----------------------------------------------------------------------------
module usb_ctrl_in_ep_buf
    import usb_ep_pkg::*;
#(
    parameter int MAX_PKT_SIZE = DEFAULT_MAX_PKT_SIZE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ep_req,
    output logic       in_ep_grant,
    output logic       in_ep_data_free,
    input  logic       in_ep_data_put,
    input  logic [7:0] in_ep_data,
    input  logic       in_ep_data_done,
    input  logic       in_ep_stall,
    output logic       in_ep_acked,
    input  logic       setup_token,
    input  logic       tx_in_token,
    output logic       tx_data_avail,
    input  logic       tx_data_get,
    output logic [7:0] tx_data,
    output logic       tx_pid_data1,
    output logic       tx_rsp_nak,
    output logic       tx_rsp_stall,
    input  logic       rx_ack,
    input  logic       tx_timeout
);

    localparam int CW = $clog2(MAX_PKT_SIZE + 1);
    localparam int AW = $clog2(MAX_PKT_SIZE);
    localparam logic [CW-1:0] FULL = CW'(MAX_PKT_SIZE);
    localparam logic [CW-1:0] LAST = CW'(MAX_PKT_SIZE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    ep_state_e     state_q, state_d;
    // Writes are strictly sequential from zero, so the byte count doubles as
    // the write pointer.
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic          toggle_q, toggle_d;
    logic          stall_q, stall_d;
    logic          acked_q, acked_d;

    logic          wr_en;
    logic          get_en;

    assign in_ep_grant     = in_ep_req;
    assign in_ep_data_free = (state_q == ST_FILL) && (count_q < FULL);
    assign tx_data_avail   = (state_q == ST_SENDING) && (rd_ptr_q < count_q);
    assign tx_pid_data1    = toggle_q;
    assign tx_rsp_nak      = (state_q == ST_FILL) && !stall_q;
    assign tx_rsp_stall    = stall_q;
    assign in_ep_acked     = acked_q;

    // SETUP and STALL pre-empt everything else in their cycle, including a
    // byte write, so the RAM only sees writes the FSM actually counts.
    assign wr_en  = in_ep_data_put && in_ep_grant && in_ep_data_free &&
                    !setup_token && !in_ep_stall;
    assign get_en = tx_data_get && tx_data_avail;

    usb_ep_pkt_ram #(
        .DEPTH (MAX_PKT_SIZE),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (in_ep_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (tx_data)
    );

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        toggle_d = toggle_q;
        stall_d  = stall_q;
        acked_d  = 1'b0;

        if (setup_token) begin
            // First data stage after SETUP is always DATA1.
            state_d  = ST_FILL;
            count_d  = '0;
            rd_ptr_d = '0;
            toggle_d = 1'b1;
            stall_d  = 1'b0;
        end else if (in_ep_stall) begin
            stall_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_FILL: begin
                    if (wr_en) begin
                        count_d = count_q + ONE;
                    end
                    if (in_ep_data_done || (wr_en && count_q == LAST)) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (tx_in_token && !stall_q) begin
                        state_d  = ST_SENDING;
                        rd_ptr_d = '0;
                    end
                end
                ST_SENDING: begin
                    if (get_en) begin
                        rd_ptr_d = rd_ptr_q + ONE;
                    end
                    if (rd_ptr_q == count_q) begin
                        state_d = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // ACK wins over a simultaneous IN token; that token is
                    // then NAKed from FILL.
                    if (rx_ack) begin
                        state_d  = ST_FILL;
                        count_d  = '0;
                        rd_ptr_d = '0;
                        toggle_d = !toggle_q;
                        acked_d  = 1'b1;
                    end else if (tx_timeout) begin
                        state_d = ST_READY;
                    end else if (tx_in_token && !stall_q) begin
                        state_d  = ST_SENDING;
                        rd_ptr_d = '0;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FILL;
            count_q  <= '0;
            rd_ptr_q <= '0;
            toggle_q <= 1'b0;
            stall_q  <= 1'b0;
            acked_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            toggle_q <= toggle_d;
            stall_q  <= stall_d;
            acked_q  <= acked_d;
        end
    end

endmodule

// File: tb/tb_usb_ctrl_in_ep_buf.sv
// -----------------------------------------------------------------------------
// tb_usb_ctrl_in_ep_buf
// Directed self-checking bench for usb_ctrl_in_ep_buf. Inputs change 1 time
// unit after the rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_usb_ctrl_in_ep_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_ep_req;
    logic       in_ep_grant;
    logic       in_ep_data_free;
    logic       in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done;
    logic       in_ep_stall;
    logic       in_ep_acked;
    logic       setup_token;
    logic       tx_in_token;
    logic       tx_data_avail;
    logic       tx_data_get;
    logic [7:0] tx_data;
    logic       tx_pid_data1;
    logic       tx_rsp_nak;
    logic       tx_rsp_stall;
    logic       rx_ack;
    logic       tx_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    usb_ctrl_in_ep_buf #(.MAX_PKT_SIZE(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_ep_req       (in_ep_req),
        .in_ep_grant     (in_ep_grant),
        .in_ep_data_free (in_ep_data_free),
        .in_ep_data_put  (in_ep_data_put),
        .in_ep_data      (in_ep_data),
        .in_ep_data_done (in_ep_data_done),
        .in_ep_stall     (in_ep_stall),
        .in_ep_acked     (in_ep_acked),
        .setup_token     (setup_token),
        .tx_in_token     (tx_in_token),
        .tx_data_avail   (tx_data_avail),
        .tx_data_get     (tx_data_get),
        .tx_data         (tx_data),
        .tx_pid_data1    (tx_pid_data1),
        .tx_rsp_nak      (tx_rsp_nak),
        .tx_rsp_stall    (tx_rsp_stall),
        .rx_ack          (rx_ack),
        .tx_timeout      (tx_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d, input logic done);
        in_ep_data_put  = 1'b1;
        in_ep_data      = d;
        in_ep_data_done = done;
        tick();
        in_ep_data_put  = 1'b0;
        in_ep_data_done = 1'b0;
    endtask

    task automatic commit();
        in_ep_data_done = 1'b1;
        tick();
        in_ep_data_done = 1'b0;
    endtask

    task automatic in_token();
        tx_in_token = 1'b1;
        tick();
        tx_in_token = 1'b0;
    endtask

    task automatic setup();
        setup_token = 1'b1;
        tick();
        setup_token = 1'b0;
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
    endtask

    // Pops every byte of exp_q while checking fall-through data, then checks
    // that the engine sees no further data.
    task automatic drain(input string tag);
        foreach (exp_q[i]) begin
            check({tag, "_avail"}, tx_data_avail, 1'b1);
            check({tag, "_data"}, tx_data, exp_q[i]);
            tx_data_get = 1'b1;
            tick();
        end
        tx_data_get = 1'b0;
        check({tag, "_end_avail"}, tx_data_avail, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_ep_req = 1'b0; in_ep_data_put = 1'b0; in_ep_data = 8'h00;
        in_ep_data_done = 1'b0; in_ep_stall = 1'b0; setup_token = 1'b0;
        tx_in_token = 1'b0; tx_data_get = 1'b0; rx_ack = 1'b0; tx_timeout = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        in_ep_req = 1'b1;

        // Reset state
        check("rst_nak",   tx_rsp_nak, 1'b1);
        check("rst_stall", tx_rsp_stall, 1'b0);
        check("rst_pid",   tx_pid_data1, 1'b0);
        check("rst_avail", tx_data_avail, 1'b0);
        check("rst_acked", in_ep_acked, 1'b0);
        check("rst_free",  in_ep_data_free, 1'b1);
        check("grant",     in_ep_grant, 1'b1);

        // 1: three-byte packet, ACK flips PID
        put(8'h12, 1'b0); put(8'h01, 1'b0); put(8'h00, 1'b0);
        check("t1_fill_free", in_ep_data_free, 1'b1);
        commit();
        check("t1_ready_free", in_ep_data_free, 1'b0);
        check("t1_ready_nak",  tx_rsp_nak, 1'b0);
        check("t1_ready_avail", tx_data_avail, 1'b0);
        in_token();
        exp_q = '{8'h12, 8'h01, 8'h00};
        drain("t1");
        tick();
        check("t1_pre_ack_pid", tx_pid_data1, 1'b0);
        ack();
        check("t1_acked", in_ep_acked, 1'b1);
        check("t1_pid",   tx_pid_data1, 1'b1);
        check("t1_nak",   tx_rsp_nak, 1'b1);
        tick();
        check("t1_acked_clr", in_ep_acked, 1'b0);

        // 2: auto-commit at 32 bytes, then an 18-byte packet with DATA0
        setup();
        check("t2_setup_pid", tx_pid_data1, 1'b1);
        exp_q = {};
        for (int i = 0; i < 32; i++) begin
            if (i == 31) check("t2_free_31", in_ep_data_free, 1'b1);
            put(8'(i), 1'b0);
            exp_q.push_back(8'(i));
        end
        check("t2_full_free", in_ep_data_free, 1'b0);
        check("t2_full_nak",  tx_rsp_nak, 1'b0);
        in_token();
        drain("t2a");
        tick();
        ack();
        check("t2_ack_pid", tx_pid_data1, 1'b0);
        exp_q = {};
        for (int i = 0; i < 18; i++) begin
            put(8'(8'h80 + i), 1'(i == 17));
            exp_q.push_back(8'(8'h80 + i));
        end
        check("t2b_ready_nak", tx_rsp_nak, 1'b0);
        in_token();
        check("t2b_pid", tx_pid_data1, 1'b0);
        drain("t2b");
        tick();
        ack();
        check("t2b_acked", in_ep_acked, 1'b1);

        // 3: zero-length DATA1, WAIT_ACK one cycle after SENDING
        setup();
        commit();
        in_token();
        check("t3_avail", tx_data_avail, 1'b0);
        check("t3_pid",   tx_pid_data1, 1'b1);
        tick();
        ack();
        check("t3_acked", in_ep_acked, 1'b1);
        check("t3_pid_flip", tx_pid_data1, 1'b0);

        // 4: timeout then replay; simultaneous ACK and IN token
        put(8'hA1, 1'b0); put(8'hB2, 1'b1);
        in_token();
        exp_q = '{8'hA1, 8'hB2};
        drain("t4a");
        tick();
        tx_timeout = 1'b1; tick(); tx_timeout = 1'b0;
        check("t4_to_nak",   tx_rsp_nak, 1'b0);
        check("t4_to_avail", tx_data_avail, 1'b0);
        check("t4_to_pid",   tx_pid_data1, 1'b0);
        in_token();
        drain("t4b");
        check("t4_replay_pid", tx_pid_data1, 1'b0);
        tick();
        rx_ack = 1'b1; tx_in_token = 1'b1;
        tick();
        rx_ack = 1'b0; tx_in_token = 1'b0;
        check("t4_both_acked", in_ep_acked, 1'b1);
        check("t4_both_pid",   tx_pid_data1, 1'b1);
        check("t4_both_nak",   tx_rsp_nak, 1'b1);
        check("t4_both_avail", tx_data_avail, 1'b0);
        tick();
        check("t4_acked_clr", in_ep_acked, 1'b0);

        // 5: STALL blocks IN tokens until SETUP
        in_ep_stall = 1'b1; tick(); in_ep_stall = 1'b0;
        check("t5_stall", tx_rsp_stall, 1'b1);
        check("t5_nak",   tx_rsp_nak, 1'b0);
        commit();
        in_token();
        check("t5_tok_avail", tx_data_avail, 1'b0);
        tick();
        check("t5_tok_avail2", tx_data_avail, 1'b0);
        setup();
        check("t5_setup_stall", tx_rsp_stall, 1'b0);
        check("t5_setup_nak",   tx_rsp_nak, 1'b1);
        check("t5_setup_pid",   tx_pid_data1, 1'b1);

        // 6: reset in SENDING after 2 of 7 bytes
        for (int i = 1; i <= 7; i++) put(8'(i), 1'(i == 7));
        in_token();
        tx_data_get = 1'b1; tick(); tick(); tx_data_get = 1'b0;
        check("t6_mid_data",  tx_data, 8'h03);
        check("t6_mid_avail", tx_data_avail, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_avail", tx_data_avail, 1'b0);
        check("t6_nak",   tx_rsp_nak, 1'b1);
        check("t6_free",  in_ep_data_free, 1'b1);
        check("t6_pid",   tx_pid_data1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
